// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state
// encodings, timeout counter width and small decode helpers.
package lsu_pkg;

  // Access size as seen on the bus; maskSel 2'b11 folds into word.
  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } lsu_state_e;

  // Width of the REQ-cycle counter; TIMEOUT_CYCLES must fit in it.
  localparam int LSU_TMO_W = 16;

  function automatic lsu_size_e lsu_size(input logic [1:0] mask_sel);
    case (mask_sel)
      2'b00:   lsu_size = LSU_B;
      2'b01:   lsu_size = LSU_H;
      default: lsu_size = LSU_W;
    endcase
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic lsu_is_misaligned(input lsu_size_e sz, input logic [1:0] a);
    case (sz)
      LSU_H:   lsu_is_misaligned = a[0];
      LSU_W:   lsu_is_misaligned = (a != 2'b00);
      default: lsu_is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_uext,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_lanes,
  output logic [31:0] o_rd_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then steer/extend according to access size.
  always_comb begin
    w_byte     = i_rd_raw[7:0];
    w_half     = i_addr_lo[1] ? i_rd_raw[31:16] : i_rd_raw[15:0];
    o_be       = 4'b1111;
    o_wr_lanes = i_wr_data;
    o_rd_ext   = i_rd_raw;
    case (i_addr_lo)
      2'b00:   w_byte = i_rd_raw[7:0];
      2'b01:   w_byte = i_rd_raw[15:8];
      2'b10:   w_byte = i_rd_raw[23:16];
      default: w_byte = i_rd_raw[31:24];
    endcase
    case (i_size)
      LSU_B: begin
        o_be       = 4'b0001 << i_addr_lo;
        o_wr_lanes = {4{i_wr_data[7:0]}};
        o_rd_ext   = {{24{~i_uext & w_byte[7]}}, w_byte};
      end
      LSU_H: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wr_lanes = {2{i_wr_data[15:0]}};
        o_rd_ext   = {{16{~i_uext & w_half[15]}}, w_half};
      end
      default: begin
        o_be       = 4'b1111;
        o_wr_lanes = i_wr_data;
        o_rd_ext   = i_rd_raw;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load or store per request over a req/ack
// word bus, stalling the core until a one-cycle done pulse.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses without issuing a bus cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRd,
  input  logic        memWr,
  input  logic [1:0]  maskSel,
  input  logic        uext,
  input  logic [31:0] addr,
  input  logic [31:0] wrData,
  output logic        stall,
  output logic [31:0] rdData,
  output logic        done,
  output logic        busErr,
  output logic        misaligned,
  output logic [31:0] busAddr,
  output logic [31:0] busWrData,
  output logic        busWe,
  output logic [3:0]  busBe,
  output logic        busReq,
  input  logic        busAck,
  input  logic [31:0] busRdData
);

  lsu_state_e           r_state;
  logic [31:0]          r_addr;
  logic [1:0]           r_size;
  logic                 r_uext;
  logic                 r_we;
  logic [3:0]           r_be;
  logic [31:0]          r_wd;
  logic [LSU_TMO_W-1:0] r_cnt;
  logic                 r_busReq;
  logic                 r_done;
  logic                 r_busErr;
  logic                 r_mis;
  logic [31:0]          r_rdData;

  logic        w_idle;
  logic        w_req;
  logic        w_mis;
  logic        w_tmo;
  lsu_size_e   w_size_live;
  logic [1:0]  w_sel_size;
  logic [1:0]  w_sel_alo;
  logic        w_sel_uext;
  logic [3:0]  w_be;
  logic [31:0] w_lanes;
  logic [31:0] w_rd_ext;

  assign w_idle      = (r_state == S_IDLE);
  assign w_req       = memRd | memWr;
  assign w_size_live = lsu_size(maskSel);

  // In IDLE the aligner sees the live request (store lanes get latched);
  // afterwards it sees the latched request (load extraction on ack).
  assign w_sel_size = w_idle ? w_size_live : r_size;
  assign w_sel_alo  = w_idle ? addr[1:0]   : r_addr[1:0];
  assign w_sel_uext = w_idle ? uext        : r_uext;

`ifdef MISALIGN_TRAP_EN
  assign w_mis = lsu_is_misaligned(w_size_live, addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Timeout fires on the last allowed REQ cycle; zero disables it.
  assign w_tmo = (TIMEOUT_CYCLES != 0) &&
                 (r_cnt == LSU_TMO_W'(TIMEOUT_CYCLES - 1));

  lsu_lane_align u_align (
    .i_size    (w_sel_size),
    .i_addr_lo (w_sel_alo),
    .i_uext    (w_sel_uext),
    .i_wr_data (wrData),
    .i_rd_raw  (busRdData),
    .o_be      (w_be),
    .o_wr_lanes(w_lanes),
    .o_rd_ext  (w_rd_ext)
  );

  // Stall rises combinationally on acceptance so the core holds this cycle.
  assign stall      = (r_state == S_REQ) | (w_idle & w_req);
  assign rdData     = r_rdData;
  assign done       = r_done;
  assign busErr     = r_busErr;
  assign misaligned = r_mis;
  assign busAddr    = {r_addr[31:2], 2'b00};
  assign busWrData  = r_wd;
  assign busWe      = r_we;
  assign busBe      = r_be;
  assign busReq     = r_busReq;

  // Access FSM: accept and latch, hold the bus request until ack or timeout,
  // then pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_size   <= '0;
      r_uext   <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wd     <= '0;
      r_cnt    <= '0;
      r_busReq <= 1'b0;
      r_done   <= 1'b0;
      r_busErr <= 1'b0;
      r_mis    <= 1'b0;
      r_rdData <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_mis) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_mis    <= 1'b1;
              r_rdData <= '0;
            end else begin
              r_state  <= S_REQ;
              r_busReq <= 1'b1;
              r_addr   <= addr;
              r_size   <= w_size_live;
              r_uext   <= uext;
              r_we     <= memWr;
              r_be     <= w_be;
              r_wd     <= w_lanes;
              r_cnt    <= '0;
            end
          end
        end
        S_REQ: begin
          if (busAck) begin
            r_state  <= S_DONE;
            r_busReq <= 1'b0;
            r_done   <= 1'b1;
            r_rdData <= r_we ? 32'd0 : w_rd_ext;
          end else if (w_tmo) begin
            r_state  <= S_DONE;
            r_busReq <= 1'b0;
            r_done   <= 1'b1;
            r_busErr <= 1'b1;
            r_rdData <= '0;
          end else begin
            r_cnt <= r_cnt + LSU_TMO_W'(1);
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_busErr <= 1'b0;
          r_mis    <= 1'b0;
          r_rdData <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
